// File: rtl/lcd_read_fsm.sv
// HD44780-style read sequencer: single RS reads and busy-flag polling with a Moore FSM.
// Optional macro POLL_TIMEOUT_EN abandons a poll after TIMEOUT_POLLS busy reads.
module lcd_read_fsm #(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned EN_CYC        = 4,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned TIMEOUT_POLLS = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       readReq,
  input  logic       pollReq,
  input  logic       RSin,
  input  logic [7:0] dataBus,
  output logic       RSout,
  output logic       RWout,
  output logic       enable,
  output logic [7:0] dataOut,
  output logic       dataValid,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [2:0] {StIdle, StSetup, StEnHi, StHold, StDone} state_e;

  localparam logic [7:0] SetupLast = 8'(SETUP_CYC - 1);
  localparam logic [7:0] EnLast    = 8'(EN_CYC - 1);
  localparam logic [7:0] HoldLast  = 8'(HOLD_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        poll_q, poll_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;

`ifdef POLL_TIMEOUT_EN
  localparam logic [7:0] PollLast = 8'(TIMEOUT_POLLS - 1);
  logic [7:0]  poll_cnt_q, poll_cnt_d;
`else
  logic [7:0]  unused_timeout_polls;
  assign unused_timeout_polls = 8'(TIMEOUT_POLLS);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      poll_q     <= 1'b0;
      rs_q       <= 1'b0;
      data_q     <= '0;
`ifdef POLL_TIMEOUT_EN
      poll_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      poll_q     <= poll_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
`ifdef POLL_TIMEOUT_EN
      poll_cnt_q <= poll_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 8'd1;
    poll_d    = poll_q;
    rs_d      = rs_q;
    data_d    = data_q;
    RSout     = 1'b0;
    RWout     = 1'b0;
    enable    = 1'b0;
    dataValid = 1'b0;
    timeout   = 1'b0;
`ifdef POLL_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        cnt_d = '0;
`ifdef POLL_TIMEOUT_EN
        poll_cnt_d = '0;
`endif
        // Poll takes priority and always reads the status register (RS=0).
        if (pollReq) begin
          state_d = StSetup;
          poll_d  = 1'b1;
          rs_d    = 1'b0;
        end else if (readReq) begin
          state_d = StSetup;
          poll_d  = 1'b0;
          rs_d    = RSin;
        end
      end
      StSetup: begin
        RSout = rs_q;
        RWout = 1'b1;
        if (cnt_q >= SetupLast) begin
          state_d = StEnHi;
          cnt_d   = '0;
        end
      end
      StEnHi: begin
        RSout  = rs_q;
        RWout  = 1'b1;
        enable = 1'b1;
        if (cnt_q >= EnLast) begin
          state_d = StHold;
          cnt_d   = '0;
          data_d  = dataBus;
        end
      end
      StHold: begin
        RSout = rs_q;
        RWout = 1'b1;
        if (cnt_q >= HoldLast) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
`ifdef POLL_TIMEOUT_EN
        if (poll_q) begin
          poll_cnt_d = poll_cnt_q + 8'd1;
        end
`endif
        if (poll_q && data_q[7]) begin
`ifdef POLL_TIMEOUT_EN
          if (poll_cnt_q >= PollLast) begin
            timeout   = 1'b1;
            dataValid = 1'b1;
          end else begin
            state_d = StSetup;
          end
`else
          state_d = StSetup;
`endif
        end else begin
          dataValid = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign dataOut = data_q;

endmodule
